// File: rtl/float_pcm_if.sv
// Sample stream bundle for the float-to-PCM sink: float samples in, PCM words out.
// in_valid is a one-cycle strobe with no back-channel; an output word moves only on a clock edge where out_valid && out_ready are both high.
interface float_pcm_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int OUT_W  = 16
);
  logic [EXP_W+MANT_W:0] in_data;
  logic                  in_valid;
  logic [OUT_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/float_pcm_sink.sv
// Converts float filter estimates to saturated, rounded fixed-point PCM and
// buffers them in a small FIFO drained over valid/ready.
module float_pcm_sink #(
  parameter int EXP_W      = 8,
  parameter int MANT_W     = 23,
  parameter int OUT_W      = 16,
  parameter int FRAC_W     = 15,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  float_pcm_if.slave                    bus,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int M_W       = MANT_W + 1;
  localparam int MAG_W     = OUT_W + 1;
  localparam int WIDE_W    = M_W + OUT_W + 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int BIAS      = (1 << (EXP_W - 1)) - 1;
  localparam int SHIFT_OFS = FRAC_W - MANT_W - BIAS;

  localparam logic [MAG_W:0] POS_MAX = (MAG_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic [MAG_W:0] NEG_MAX = (MAG_W+1)'(1 << (OUT_W - 1));

  // ---------------- decode (combinational, feeds stage 1) ----------------
  logic               in_sign;
  logic [EXP_W-1:0]   in_exp;
  logic [MANT_W-1:0]  in_mant;
  logic [M_W-1:0]     m;
  int                 shift_amt;
  logic [WIDE_W-1:0]  wide;
  logic [M_W:0]       rnd_vec;
  logic               d_big;
  logic [MAG_W-1:0]   d_mag;
  logic               d_rnd;

  assign {in_sign, in_exp, in_mant} = bus.in_data;
  assign m = {1'b1, in_mant};

  // d_big marks any magnitude >= 2^OUT_W, which saturates regardless of sign
  // or rounding, so the stage-1 magnitude never needs more than OUT_W+1 bits.
  always_comb begin
    shift_amt = int'(in_exp) + SHIFT_OFS;
    wide      = '0;
    rnd_vec   = '0;
    d_big     = 1'b0;
    d_mag     = '0;
    d_rnd     = 1'b0;
    if (in_exp == '0) begin
      d_big = 1'b0;
    end else if (in_exp == '1) begin
      d_big = 1'b1;
    end else if (shift_amt >= 0) begin
      if (shift_amt > OUT_W) begin
        d_big = 1'b1;
      end else begin
        wide  = WIDE_W'(m) << shift_amt;
        d_big = |wide[WIDE_W-1:OUT_W];
        d_mag = wide[MAG_W-1:0];
      end
    end else begin
      // Bit 0 of {m,0} >> n is m[n-1], the last discarded bit; large n yields 0.
      wide    = WIDE_W'(m) >> (-shift_amt);
      rnd_vec = {m, 1'b0} >> (-shift_amt);
      d_big   = |wide[WIDE_W-1:OUT_W];
      d_mag   = wide[MAG_W-1:0];
      d_rnd   = rnd_vec[0];
    end
  end

  // ---------------- stage 1 ----------------
  logic             s1_valid;
  logic             s1_sign;
  logic             s1_big;
  logic [MAG_W-1:0] s1_mag;
  logic             s1_rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_big   <= 1'b0;
      s1_mag   <= '0;
      s1_rnd   <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      s1_sign  <= in_sign;
      s1_big   <= d_big;
      s1_mag   <= d_mag;
      s1_rnd   <= d_rnd;
    end
  end

  // ---------------- round and saturate ----------------
  logic [MAG_W:0]   rounded;
  logic [OUT_W-1:0] word;
  logic             word_sat;

  assign rounded = {1'b0, s1_mag} + (MAG_W+1)'(s1_rnd);

  // Negative side admits one extra code: -2^(OUT_W-1) is exact, not saturated.
  always_comb begin
    word     = '0;
    word_sat = 1'b0;
    if (!s1_sign) begin
      if (s1_big || (rounded > POS_MAX)) begin
        word     = {1'b0, {(OUT_W-1){1'b1}}};
        word_sat = 1'b1;
      end else begin
        word = rounded[OUT_W-1:0];
      end
    end else begin
      if (s1_big || (rounded > NEG_MAX)) begin
        word     = {1'b1, {(OUT_W-1){1'b0}}};
        word_sat = 1'b1;
      end else begin
        word = '0 - rounded[OUT_W-1:0];
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic             s2_valid;
  logic [OUT_W-1:0] s2_data;
  logic             s2_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_data  <= word;
      s2_sat   <= word_sat;
    end
  end

  // ---------------- output FIFO ----------------
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [OUT_W-1:0] hold_data;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && bus.out_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok = s2_valid && (!full || pop);
  assign drop    = s2_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr[AW-1:0]] <= s2_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sat_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
      drop_count <= '0;
      hold_data  <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sat_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
      drop_count <= '0;
      hold_data  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && s2_sat) begin
        sat_flag <= 1'b1;
      end
      if (drop) begin
        ovf_flag <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end
      hold_data <= bus.out_data;
    end
  end

  // hold_data keeps the last presented word visible while the FIFO is empty.
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? hold_data : mem[rd_ptr[AW-1:0]];
  assign level         = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_float_pcm_sink.sv
// Self-checking bench for float_pcm_sink: scoreboard queue of expected PCM
// words, fixed conversion vectors, backpressure, clear and reset scenarios.
module tb_float_pcm_sink;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [3:0]  level;
  logic        sat_flag;
  logic        ovf_flag;
  logic [15:0] drop_count;

  float_pcm_if #(.EXP_W(8), .MANT_W(23), .OUT_W(16)) bus ();

  float_pcm_sink #(
    .EXP_W(8), .MANT_W(23), .OUT_W(16), .FRAC_W(15), .FIFO_DEPTH(8), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .level      (level),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .drop_count (drop_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference conversion: value * 2^15 = m * 2^(exp - 150 + 15), rounded half away.
  function automatic logic [15:0] model(input logic [31:0] f);
    int     e;
    int     n;
    longint mm;
    longint mag;
    bit     big;
    e   = int'(f[30:23]);
    mm  = longint'({1'b1, f[22:0]});
    mag = 0;
    big = 1'b0;
    if (e == 255) begin
      big = 1'b1;
    end else if (e != 0) begin
      n = 135 - e;
      if (n <= 0) big = 1'b1;
      else if (n < 40) mag = (mm >> n) + ((mm >> (n - 1)) & 1);
    end
    if (!f[31]) return (big || mag > 32767) ? 16'h7FFF : mag[15:0];
    else        return (big || mag > 32768) ? 16'h8000 : 16'(-mag);
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_exp(input logic [31:0] d, input logic [15:0] e, input bit keep);
    @(posedge clk); #1;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    if (keep) exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] d, input bit keep);
    send_exp(d, model(d), keep);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    clear        = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    bus.out_ready = v;
    bus.in_valid  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_level(input int target);
    int k;
    k = 0;
    while (int'(level) != target && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("wait_level", 32'(level), 32'(target));
  endtask

  task automatic latency_probe(input logic [31:0] d, input logic [15:0] e);
    send_exp(d, e, 1'b1);
    idle();
    @(negedge clk); check("lat_e0_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_e1_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check("lat_e2_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk); check("lat_e3_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_level"},    32'(level),         32'd0);
    check({tag, "_valid"},    32'(bus.out_valid), 32'd0);
    check({tag, "_sat"},      32'(sat_flag),      32'd0);
    check({tag, "_ovf"},      32'(ovf_flag),      32'd0);
    check({tag, "_drop"},     32'(drop_count),    32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] f;
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check_cleared("reset");
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    rst = 1'b0;

    // Basic conversion and latency
    set_ready(1'b1);
    latency_probe(32'h3F000000, 16'h4000);
    send_exp(32'hBF800000, 16'h8000, 1'b1);
    idle();
    drain("drain_neg1");
    check("sat_after_neg1", 32'(sat_flag), 32'd0);

    // Saturation and rounding vectors
    send_exp(32'h3F800000, 16'h7FFF, 1'b1);
    send_exp(32'hFF800000, 16'h8000, 1'b1);
    send_exp(32'h00000001, 16'h0000, 1'b1);
    send_exp(32'h37800000, 16'h0001, 1'b1);
    send_exp(32'hB7800000, 16'hFFFF, 1'b1);
    send_exp(32'h37000000, 16'h0000, 1'b1);
    send_exp(32'h7FC00000, 16'h7FFF, 1'b1);
    idle();
    drain("drain_vectors");
    check("sat_after_vectors", 32'(sat_flag), 32'd1);
    check("ovf_after_vectors", 32'(ovf_flag), 32'd0);

    // Backpressure: 10 samples into an 8-deep FIFO, last 2 dropped
    set_ready(1'b0);
    for (int i = 0; i < 10; i++) send(32'h3E000000 | (32'(i) << 18), i < 8);
    idle();
    wait_level(8);
    repeat (3) @(negedge clk);
    check("bp_level", 32'(level),      32'd8);
    check("bp_ovf",   32'(ovf_flag),   32'd1);
    check("bp_drop",  32'(drop_count), 32'd2);
    set_ready(1'b1);
    drain("drain_bp");

    // Full FIFO with simultaneous push and pop
    set_ready(1'b0);
    for (int i = 0; i < 8; i++) send(32'hBE400000 | (32'(i) << 17), 1'b1);
    idle();
    wait_level(8);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      f            = 32'h3D800000 | (32'(i) << 16);
      bus.in_data  = f;
      bus.in_valid = 1'b1;
      exp_q.push_back(model(f));
      if (i == 2) bus.out_ready = 1'b1;
      @(negedge clk);
      check("full_pp_level", 32'(level),      32'd8);
      check("full_pp_drop",  32'(drop_count), 32'd2);
    end
    idle();
    drain("drain_full_pp");

    // Clear with 5 queued and one sample in flight
    set_ready(1'b0);
    send(32'h3F800000, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h3E800000 | (32'(i) << 20), 1'b1);
    idle();
    wait_level(5);
    check("pre_clear_sat", 32'(sat_flag), 32'd1);
    send(32'h3E900000, 1'b0);
    @(posedge clk); #1;
    bus.in_data  = 32'h3EA00000;
    bus.in_valid = 1'b1;
    clear        = 1'b1;
    idle();
    exp_q.delete();
    @(negedge clk);
    check_cleared("clear");
    repeat (3) @(negedge clk);
    check("clear_late_level", 32'(level), 32'd0);
    set_ready(1'b1);
    latency_probe(32'h3E800000, 16'h2000);

    // Asynchronous reset pulse mid-stream
    set_ready(1'b0);
    send(32'h3F800000, 1'b0);
    send(32'h3F000000, 1'b0);
    send(32'h3E000000, 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_sat", 32'(sat_flag), 32'd1);
    #2;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check_cleared("rst_pulse");
    check("rst_pulse_out_data", 32'(bus.out_data), 32'd0);
    #2;
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("rst_late_level", 32'(level), 32'd0);
    set_ready(1'b1);
    latency_probe(32'hBF000000, 16'hC000);

    // Random traffic with random backpressure, gated so nothing drops
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (int'(level) < 5 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 9))
          0:       f = {1'($urandom_range(0, 1)), 8'd0,   23'($urandom)};
          1:       f = {1'($urandom_range(0, 1)), 8'd255, 23'($urandom)};
          default: f = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 140)), 23'($urandom)};
        endcase
        bus.in_data  = f;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(f));
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    set_ready(1'b1);
    drain("drain_random");
    check("final_ovf",  32'(ovf_flag),   32'd0);
    check("final_drop", 32'(drop_count), 32'd0);
    check("final_level", 32'(level),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/float_pcm_sink.md
# float_pcm_sink

Output stage of the batch filter. Accepts one float filter estimate per downsampled sample (the filter's `floatType` output plus a strobe), converts it to saturated, rounded signed fixed-point PCM, and buffers the results in a small FIFO. Downstream consumers drain the FIFO over a valid/ready handshake. Overflow and saturation events are reported through sticky flags and a drop counter.

## Interface
- `EXP_W`, 8: float exponent width; bias = 2^(EXP_W-1)-1.
- `MANT_W`, 23: float stored-mantissa width; hidden leading one.
- `OUT_W`, 16: PCM output width, two's complement.
- `FRAC_W`, 15: fractional bits of PCM; full scale 1.0 = 2^FRAC_W.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, >= 2.
- `CNT_W`, 16: drop counter width.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush: empties pipeline and FIFO, clears flags and counter.
- `in_data`  in  1+EXP_W+MANT_W  float sample, fields {sign, exp, mant} MSB first.
- `in_valid`  in  1  one-cycle strobe, sample present on `in_data`.
- `out_data`  out  OUT_W  PCM word at FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `sat_flag`  out  1  sticky: some sample saturated.
- `ovf_flag`  out  1  sticky: some sample dropped on full FIFO.
- `drop_count`  out  CNT_W  dropped samples, saturates at all-ones.

## Operation
- Decode: exp==0 → value 0 (zero and denormals flushed). exp==all-ones → saturate toward sign (inf/NaN). Otherwise m = {1, mant}, shift = exp - bias + FRAC_W - MANT_W.
- Magnitude: shift >= 0 → m << shift, evaluated wide enough to detect overflow. shift < 0 → m >> -shift, rounded half away from zero using the last discarded bit. Shift beyond m width → 0.
- Sign/saturate:
  - Positive: magnitude > 2^(OUT_W-1)-1 → 2^(OUT_W-1)-1.
  - Negative: magnitude > 2^(OUT_W-1) → -2^(OUT_W-1); otherwise the result is negated. Exactly -2^(OUT_W-1) does not saturate.
  - Any saturation, including inf/NaN, sets `sat_flag`.
- Pipeline:
  - Stage 1 registers the decoded sign/class/shifted magnitude/round bit.
  - Stage 2 registers the rounded, saturated word plus a valid bit.
  - The stage-2 valid pushes into the FIFO.
- FIFO: circular buffer with read/write pointers one bit wider than the address; full/empty derived from the pointers.
  - Push with full FIFO and no same-cycle pop → sample dropped, `ovf_flag` set, `drop_count` +1 (saturating).
  - Push and pop in the same cycle while full → both succeed, level unchanged.
- Pipeline never stalls; `in_valid` is always accepted.
- `clear` has priority over all same-cycle events: the in-flight sample and the incoming sample are discarded.

## Timing
- Reset (async assert, registers cleared immediately):
  - `out_data`=0, `out_valid`=0, `level`=0.
  - `sat_flag`=0, `ovf_flag`=0, `drop_count`=0.
  - Pipeline valids=0.
- Latency: `in_valid` sampled at edge E0 → stage 2 at E1 → FIFO write at E2. With an empty FIFO, `out_valid`/`out_data` update right after E2.
- Throughput: one sample per cycle sustained (back-to-back `in_valid` legal).
- Pop occurs at an edge where `out_valid && out_ready`; the next head appears after that edge. `out_data` is held while `out_valid`=0.
- Flags set at the edge where the event's sample enters the FIFO (sat) or is dropped (ovf).
- Reset or `clear` mid-stream: no partial word is ever output; the first post-clear sample follows the normal E0→E2 latency.

## Test plan
- Basic conversion, `out_ready`=1:
  - 0x3F000000 (0.5) → 0x4000 at E2; `out_valid` 1 cycle.
  - 0xBF800000 (-1.0) → 0x8000, `sat_flag`=0.
- Saturation:
  - 0x3F800000 (1.0) → 0x7FFF, `sat_flag`=1.
  - 0xFF800000 (-inf) → 0x8000.
  - 0x00000001 (denormal) → 0x0000.
- Rounding:
  - 0x37800000 (2^-16) → 0x0001.
  - 0xB7800000 → 0xFFFF.
  - 0x37000000 (2^-17) → 0x0000.
- Backpressure: `out_ready`=0, 10 back-to-back samples → `level`=8, `ovf_flag`=1, `drop_count`=2. Then `out_ready`=1 → first 8 samples drained in order.
- Full-FIFO simultaneous push/pop: FIFO full, `out_ready`=1 with continuous input → `level` stays 8, `drop_count` unchanged.
- `clear` with 5 queued and one sample in flight → next cycle `level`=0, `out_valid`=0, flags/counter 0. Async `rst` pulse mid-stream gives the same result immediately.
